// File: rtl/green_xy_detect.sv
// Green-dominance point detector: pairs RGB565 camera bytes into pixels, tracks column/row
// and strobes (x,y) for green pixels. Optional XY_DECIMATE_EN keeps only the 4x4 grid.
module green_xy_detect #(
    parameter int unsigned H_RES      = 320,
    parameter int unsigned V_RES      = 240,
    parameter int unsigned G_MIN      = 32,
    parameter int unsigned G_MARGIN   = 8,
    parameter int unsigned MAX_POINTS = 1023
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    input  logic       href_i,
    input  logic       vsync_i,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       xy_valid,
    output logic       xy_refresh,
    output logic [9:0] point_count,
    output logic       overflow_o
);

    localparam logic [6:0] G_MIN7     = 7'(G_MIN);
    localparam logic [6:0] G_MARGIN7  = 7'(G_MARGIN);
    localparam logic [9:0] H_RES10    = 10'(H_RES);
    localparam logic [9:0] V_RES10    = 10'(V_RES);
    localparam logic [9:0] MAX_PTS10  = 10'(MAX_POINTS);
    localparam logic [8:0] CNT_MAX    = 9'd511;

    // Input edge detect and byte pairing
    logic       vsync_q, href_q, armed_q, armed_d;
    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;
    logic [8:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;

    // S1 pixel register
    logic       s1_valid_q, s1_valid_d;
    logic [4:0] s1_r_q, s1_r_d, s1_b_q, s1_b_d;
    logic [5:0] s1_g_q, s1_g_d;
    logic [8:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;

    // Output registers
    logic [8:0] x_q, x_d, y_q, y_d;
    logic       xy_valid_q, xy_valid_d, xy_refresh_q, xy_refresh_d;
    logic [9:0] point_count_q, point_count_d;
    logic       overflow_q, overflow_d;

    logic frame_start, line_end, byte_ok;
    logic g_ok, in_range, grid_ok, emit_ok;
    logic [6:0] g7, r_lim, b_lim;

    assign frame_start = vsync_i & ~vsync_q;
    assign line_end    = href_q & ~href_i;
    assign byte_ok     = href_i & data_valid_i & ~frame_start;

    // 7-bit sums cannot wrap: 2*31 + 63 < 128
    assign g7    = {1'b0, s1_g_q};
    assign r_lim = {1'b0, s1_r_q, 1'b0} + G_MARGIN7;
    assign b_lim = {1'b0, s1_b_q, 1'b0} + G_MARGIN7;
    assign g_ok  = (g7 >= G_MIN7) && (g7 >= r_lim) && (g7 >= b_lim);

    assign in_range = ({1'b0, s1_x_q} < H_RES10) && ({1'b0, s1_y_q} < V_RES10);

`ifdef XY_DECIMATE_EN
    assign grid_ok = (s1_x_q[1:0] == 2'b00) && (s1_y_q[1:0] == 2'b00);
`else
    assign grid_ok = 1'b1;
`endif

    assign emit_ok = s1_valid_q & g_ok & armed_q & in_range & ~overflow_q & grid_ok;

    always_comb begin
        // NOTE: every next-state signal gets its default first so no path leaves it unassigned (no latch).
        armed_d       = armed_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        s1_valid_d    = 1'b0;
        s1_r_d        = s1_r_q;
        s1_g_d        = s1_g_q;
        s1_b_d        = s1_b_q;
        s1_x_d        = s1_x_q;
        s1_y_d        = s1_y_q;
        x_d           = x_q;
        y_d           = y_q;
        xy_valid_d    = 1'b0;
        xy_refresh_d  = frame_start;
        point_count_d = point_count_q;
        overflow_d    = overflow_q;

        if (frame_start) begin
            // Frame start wins: flush S1/emit, drop any same-cycle byte, clear counters.
            armed_d       = 1'b1;
            phase_d       = 1'b0;
            x_cnt_d       = '0;
            y_cnt_d       = '0;
            point_count_d = '0;
            overflow_d    = 1'b0;
        end else begin
            if (line_end) begin
                x_cnt_d = '0;
                phase_d = 1'b0;
                y_cnt_d = (y_cnt_q == CNT_MAX) ? y_cnt_q : y_cnt_q + 9'd1;
            end else if (byte_ok) begin
                if (!phase_q) begin
                    hi_d    = data_i;
                    phase_d = 1'b1;
                end else begin
                    phase_d    = 1'b0;
                    s1_valid_d = 1'b1;
                    s1_r_d     = hi_q[7:3];
                    s1_g_d     = {hi_q[2:0], data_i[7:5]};
                    s1_b_d     = data_i[4:0];
                    s1_x_d     = x_cnt_q;
                    s1_y_d     = y_cnt_q;
                    x_cnt_d    = (x_cnt_q == CNT_MAX) ? x_cnt_q : x_cnt_q + 9'd1;
                end
            end

            if (emit_ok) begin
                xy_valid_d    = 1'b1;
                x_d           = s1_x_q;
                y_d           = s1_y_q;
                point_count_d = point_count_q + 10'd1;
                if (point_count_q + 10'd1 == MAX_PTS10)
                    overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            armed_q       <= 1'b0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            s1_valid_q    <= 1'b0;
            s1_r_q        <= '0;
            s1_g_q        <= '0;
            s1_b_q        <= '0;
            s1_x_q        <= '0;
            s1_y_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            xy_valid_q    <= 1'b0;
            xy_refresh_q  <= 1'b0;
            point_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            vsync_q       <= vsync_i;
            href_q        <= href_i;
            armed_q       <= armed_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            s1_valid_q    <= s1_valid_d;
            s1_r_q        <= s1_r_d;
            s1_g_q        <= s1_g_d;
            s1_b_q        <= s1_b_d;
            s1_x_q        <= s1_x_d;
            s1_y_q        <= s1_y_d;
            x_q           <= x_d;
            y_q           <= y_d;
            xy_valid_q    <= xy_valid_d;
            xy_refresh_q  <= xy_refresh_d;
            point_count_q <= point_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign xy_valid    = xy_valid_q;
    assign xy_refresh  = xy_refresh_q;
    assign point_count = point_count_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_green_xy_detect.sv
// Directed bench for green_xy_detect (MAX_POINTS=4); records every emit with its cycle
// and compares against hand-computed coordinates and latencies.
module tb_green_xy_detect;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] data_i;
    logic       data_valid_i, href_i, vsync_i;
    logic [8:0] x, y;
    logic       xy_valid, xy_refresh;
    logic [9:0] point_count;
    logic       overflow_o;

    green_xy_detect #(.MAX_POINTS(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .data_valid_i(data_valid_i),
        .href_i(href_i), .vsync_i(vsync_i), .x(x), .y(y), .xy_valid(xy_valid),
        .xy_refresh(xy_refresh), .point_count(point_count), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int ex; int ey; int cyc; } emit_t;
    emit_t emits[$];
    int cyc = 0;
    int refresh_cnt = 0;
    int both_cnt = 0;
    int tests_run = 0;
    int tests_failed = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (xy_valid) emits.push_back('{int'(x), int'(y), cyc});
        if (xy_refresh) refresh_cnt++;
        if (xy_valid && xy_refresh) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int emit_x(input int i);
        return (i < emits.size()) ? emits[i].ex : -1;
    endfunction
    function automatic int emit_y(input int i);
        return (i < emits.size()) ? emits[i].ey : -1;
    endfunction
    function automatic int emit_cyc(input int i);
        return (i < emits.size()) ? emits[i].cyc : -1;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [7:0] b, input logic v, input logic h, input logic vs);
        data_i = b; data_valid_i = v; href_i = h; vsync_i = vs;
        tick();
    endtask

    task automatic pixel(input logic [15:0] p, output int lo_cyc);
        drive(p[15:8], 1'b1, 1'b1, 1'b0);
        lo_cyc = cyc;
        drive(p[7:0], 1'b1, 1'b1, 1'b0);
    endtask

    task automatic line_end();
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame_start();
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int lc [4];
        int lo, rc0;
        int exp_x [4];
        int exp_y [4];

        reset_i = 1'b1;
        data_i = 8'h00; data_valid_i = 1'b0; href_i = 1'b0; vsync_i = 1'b0;
        repeat (3) tick();
        check("rst_xy_valid", 32'(xy_valid), 32'd0);
        check("rst_refresh", 32'(xy_refresh), 32'd0);
        check("rst_count", 32'(point_count), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        reset_i = 1'b0;
        tick();

        // 1: not armed before the first vsync edge
        emits.delete();
        for (int i = 0; i < 3; i++) pixel(16'h07E0, lo);
        line_end();
        check("t1_no_emit", 32'(emits.size()), 32'd0);
        check("t1_no_refresh", 32'(refresh_cnt), 32'd0);

        // 2: first frame, four pixels on line 0
        rc0 = refresh_cnt;
        frame_start();
        check("t2_refresh", 32'(refresh_cnt - rc0), 32'd1);
        check("t2_count0", 32'(point_count), 32'd0);
        emits.delete();
        pixel(16'h0000, lc[0]);
        pixel(16'h07E0, lc[1]);
        pixel(16'h07E0, lc[2]);
        pixel(16'hF800, lc[3]);
        line_end();
        check("t2_n", 32'(emits.size()), 32'd2);
        check("t2_x0", 32'(emit_x(0)), 32'd1);
        check("t2_y0", 32'(emit_y(0)), 32'd0);
        check("t2_lat0", 32'(emit_cyc(0)), 32'(lc[1] + 2));
        check("t2_x1", 32'(emit_x(1)), 32'd2);
        check("t2_y1", 32'(emit_y(1)), 32'd0);
        check("t2_lat1", 32'(emit_cyc(1)), 32'(lc[2] + 2));
        check("t2_count", 32'(point_count), 32'd2);

        // 3: three lines, green at x=5, stray byte at end of line 1
        frame_start();
        emits.delete();
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < 6; c++) pixel((c == 5) ? 16'h07E0 : 16'h0000, lo);
            if (l == 1) drive(8'h07, 1'b1, 1'b1, 1'b0);
            line_end();
        end
        check("t3_n", 32'(emits.size()), 32'd3);
        for (int l = 0; l < 3; l++) begin
            check($sformatf("t3_x%0d", l), 32'(emit_x(l)), 32'd5);
            check($sformatf("t3_y%0d", l), 32'(emit_y(l)), 32'(l));
        end
        check("t3_count", 32'(point_count), 32'd3);
        check("t3_overflow", 32'(overflow_o), 32'd0);

        // 4: emit cap at 4
        frame_start();
        emits.delete();
        for (int c = 0; c < 8; c++) pixel(16'h07E0, lo);
        line_end();
        check("t4_n", 32'(emits.size()), 32'd4);
        check("t4_last_x", 32'(emit_x(3)), 32'd3);
        check("t4_count", 32'(point_count), 32'd4);
        check("t4_overflow", 32'(overflow_o), 32'd1);
        frame_start();
        check("t4_count_clr", 32'(point_count), 32'd0);
        check("t4_overflow_clr", 32'(overflow_o), 32'd0);

        // 5b: vsync the cycle after a green lo byte flushes S1
        emits.delete();
        rc0 = refresh_cnt;
        pixel(16'h07E0, lo);
        drive(8'h00, 1'b0, 1'b1, 1'b1);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        check("t5b_no_emit", 32'(emits.size()), 32'd0);
        check("t5b_refresh", 32'(refresh_cnt - rc0), 32'd1);
        // 5a: vsync coincident with the lo byte drops it
        drive(8'h07, 1'b1, 1'b1, 1'b0);
        drive(8'hE0, 1'b1, 1'b1, 1'b1);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        check("t5a_no_emit", 32'(emits.size()), 32'd0);
        check("t5a_refresh", 32'(refresh_cnt - rc0), 32'd2);
        check("t5a_count", 32'(point_count), 32'd0);
        pixel(16'h07E0, lo);
        line_end();
        check("t5_after_n", 32'(emits.size()), 32'd1);
        check("t5_after_x", 32'(emit_x(0)), 32'd0);
        check("t5_after_y", 32'(emit_y(0)), 32'd0);
        check("t5_after_lat", 32'(emit_cyc(0)), 32'(lo + 2));

        // 6: all-green 8x8 region at the origin
        frame_start();
        emits.delete();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) pixel(16'h07E0, lo);
            line_end();
        end
`ifdef XY_DECIMATE_EN
        exp_x = '{0, 4, 0, 4};
        exp_y = '{0, 0, 4, 4};
`else
        exp_x = '{0, 1, 2, 3};
        exp_y = '{0, 0, 0, 0};
`endif
        check("t6_n", 32'(emits.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6_x%0d", i), 32'(emit_x(i)), 32'(exp_x[i]));
            check($sformatf("t6_y%0d", i), 32'(emit_y(i)), 32'(exp_y[i]));
        end
        check("t6_overflow", 32'(overflow_o), 32'd1);

        check("valid_refresh_overlap", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
